// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable RV32 data memory behind a registered
// request/response handshake with programmable wait states.
// Supports LB/LH/LW/LBU/LHU and SB/SH/SW (little-endian, byte-lane writes,
// sign/zero extension) and flags illegal-funct3, out-of-range and
// (optionally) misaligned accesses.
// Optional feature macro: DATA_MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/SH/LW/SW fault with rsp_err=1, no write
//   undefined -> misaligned halfword/word addresses are force-aligned
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   // NOTE: the word array has no reset; its contents survive rst and only
   // the power-up values below are defined.
   logic [31:0] mem_q [DEPTH_WORDS] = '{0: 32'd17, 1: 32'd9, 2: 32'd25, default: 32'd0};

   logic [ADDR_WIDTH-3:0] word_idx;
   logic [IDX_W-1:0]      mem_idx;
   logic                  in_range;
   logic                  f3_ok;
   logic                  access_err;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;
   logic [3:0]            wr_be;
   logic [31:0]           wr_data;
   logic                  mem_we;

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Decode the latched request: legality, range, alignment, load data and byte enables.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      word_idx   = addr_q[ADDR_WIDTH-1:2];
      mem_idx    = word_idx[IDX_W-1:0];
      in_range   = (32'(word_idx) < 32'(DEPTH_WORDS));
      f3_ok      = 1'b0;
      access_err = 1'b0;
      rd_word    = mem_q[mem_idx];
      rd_byte    = rd_word[{addr_q[1:0], 3'b000} +: 8];
      rd_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      load_data  = 32'd0;
      wr_be      = 4'b0000;
      wr_data    = wdata_q;

      if (we_q) f3_ok = (funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W);
      else      f3_ok = (funct3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef DATA_MEM_MISALIGN_TRAP_EN
      access_err = !f3_ok || !in_range ||
                   ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
      // Half/word selection ignores addr[0] / addr[1:0], which force-aligns.
      access_err = !f3_ok || !in_range;
`endif

      case (funct3_q)
         F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
         F3_BU:   load_data = {24'd0, rd_byte};
         F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
         F3_HU:   load_data = {16'd0, rd_half};
         F3_W:    load_data = rd_word;
         default: load_data = 32'd0;
      endcase

      case (funct3_q[1:0])
         2'b00: begin
            wr_be   = 4'b0001 << addr_q[1:0];
            wr_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
         end
         default: wr_be = 4'b1111;
      endcase

      mem_we = (state_q == S_WAIT) && (cnt_q == 4'd0) && we_q && !access_err;
   end

   // Next-state logic: accept in IDLE, count down wait states, access, hold response.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cnt_d    = 4'(WAIT_STATES);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_err_d   = access_err;
               rsp_rdata_d = (access_err || we_q) ? 32'd0 : load_data;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Byte-lane write into the word array on the access edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for data_mem_ctrl. Two instances share the
// request bus: dut a has no wait states, dut b has three. A byte-level memory
// model computes every expected response; literal values pin the model.
module tb_data_mem_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 64;
   localparam int WS_A  = 0;
   localparam int WS_B  = 3;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   logic          clk;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    rsp_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;

   logic          req_ready_a, req_ready_b;
   logic          rsp_valid_a, rsp_valid_b;
   logic [31:0]   rsp_rdata_a, rsp_rdata_b;
   logic          rsp_err_a, rsp_err_b;

   int            n_vec;
   int            n_bad;
   bit            cmp_en;
   bit            outstanding [2];
   int            elapsed [2];
   logic [31:0]   exp_rdata [2];
   logic          exp_err [2];
   logic [31:0]   mdl_mem [2][DEPTH];

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(WS_A)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready_a),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
   );

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(WS_B)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready_b),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? WS_A : WS_B;
   endfunction

   function automatic logic get_ready(input int d);
      return (d == 0) ? req_ready_a : req_ready_b;
   endfunction

   function automatic logic get_valid(input int d);
      return (d == 0) ? rsp_valid_a : rsp_valid_b;
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      return (d == 0) ? rsp_rdata_a : rsp_rdata_b;
   endfunction

   function automatic logic get_err(input int d);
      return (d == 0) ? rsp_err_a : rsp_err_b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Byte-level reference: size/sign from funct3, then move bytes one at a time.
   task automatic mdl_access(input int d, input bit we, input logic [2:0] f3,
                             input logic [AW-1:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err);
      int          idx, lane, size;
      bit          uns, legal;
      logic [31:0] w;
      idx   = int'(addr) / 4;
      lane  = int'(addr) % 4;
      rd    = 32'd0;
      err   = 1'b0;
      uns   = 1'b0;
      legal = 1'b1;
      size  = 4;
      case (f3)
         3'b000:  size = 1;
         3'b001:  size = 2;
         3'b010:  size = 4;
         3'b100:  begin size = 1; uns = 1'b1; legal = !we; end
         3'b101:  begin size = 2; uns = 1'b1; legal = !we; end
         default: legal = 1'b0;
      endcase
      if (!legal || idx >= DEPTH) begin
         err = 1'b1;
      end else if (lane % size != 0) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
         err = 1'b1;
`else
         lane = lane - (lane % size);
`endif
      end
      if (!err) begin
         w = mdl_mem[d][idx];
         if (we) begin
            for (int b = 0; b < size; b++) w[8*(lane+b) +: 8] = wdata[8*b +: 8];
            mdl_mem[d][idx] = w;
         end else begin
            for (int b = 0; b < size; b++) rd[8*b +: 8] = w[8*(lane+b) +: 8];
            if (!uns && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s dut%0d req_ready", tag, d), 32'(get_ready(d)), 32'd1);
         check($sformatf("%s dut%0d rsp_valid", tag, d), 32'(get_valid(d)), 32'd0);
         check($sformatf("%s dut%0d rsp_rdata", tag, d), get_rdata(d), 32'd0);
         check($sformatf("%s dut%0d rsp_err", tag, d), 32'(get_err(d)), 32'd0);
      end
   endtask

   // One request/response on dut d; rsp_ready stays low for 'hold' cycles after accept.
   task automatic do_txn(input int d, input bit we, input logic [2:0] f3,
                         input logic [AW-1:0] addr, input logic [31:0] wdata, input int hold,
                         input logic [31:0] lit_rd, input logic lit_err, input string name);
      logic [31:0] m_rd;
      logic        m_err;
      bit          hs;
      mdl_access(d, we, f3, addr, wdata, m_rd, m_err);
      check({name, " model rdata"}, m_rd, lit_rd);
      check({name, " model err"}, 32'(m_err), 32'(lit_err));
      exp_rdata[d] = m_rd;
      exp_err[d]   = m_err;
      @(negedge clk);
      req_we       = we;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid[d] = 1'b1;
      rsp_ready[d] = (hold == 0);
      @(posedge clk);
      #1;
      outstanding[d] = 1'b1;
      elapsed[d]     = 0;
      // Scramble the bus while busy; the latched request must be used.
      req_we     = ~we;
      req_funct3 = ~f3;
      req_addr   = ~addr;
      req_wdata  = ~wdata;
      hs = 1'b0;
      for (int k = 0; k < 40 && !hs; k++) begin
         @(negedge clk);
         if (k >= hold) rsp_ready[d] = 1'b1;
         hs = get_valid(d) && rsp_ready[d];
         @(posedge clk);
         #1;
         elapsed[d]++;
         if (hs) begin
            outstanding[d] = 1'b0;
            req_valid[d]   = 1'b0;
         end
      end
      if (!hs) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s handshake: no response within 40 cycles", name);
         outstanding[d] = 1'b0;
         req_valid[d]   = 1'b0;
      end
   endtask

   // Per-cycle compare of handshake timing and held response against the model.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
               exp_v = outstanding[d] && (elapsed[d] >= ws_of(d) + 1);
               check($sformatf("dut%0d req_ready", d), 32'(get_ready(d)), 32'(!outstanding[d]));
               check($sformatf("dut%0d rsp_valid", d), 32'(get_valid(d)), 32'(exp_v));
               if (exp_v) begin
                  check($sformatf("dut%0d rsp_rdata", d), get_rdata(d), exp_rdata[d]);
                  check($sformatf("dut%0d rsp_err", d), 32'(get_err(d)), 32'(exp_err[d]));
               end
            end
         end
      end
   end

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      cmp_en     = 1'b0;
      rst        = 1'b1;
      req_valid  = 2'b00;
      rsp_ready  = 2'b11;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = 32'd0;
      for (int d = 0; d < 2; d++) begin
         outstanding[d] = 1'b0;
         elapsed[d]     = 0;
         exp_rdata[d]   = 32'd0;
         exp_err[d]     = 1'b0;
         for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = 32'd0;
         mdl_mem[d][0] = 32'd17;
         mdl_mem[d][1] = 32'd9;
         mdl_mem[d][2] = 32'd25;
      end

      repeat (2) @(negedge clk);
      chk_reset("in reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset("after reset");
      cmp_en = 1'b1;

      // Zero-wait-state instance: loads, stores, extension.
      do_txn(0, 1'b0, LW,  10'h004, 32'h0,        0, 32'd9,        1'b0, "LW 0x04");
      do_txn(0, 1'b1, SW,  10'h010, 32'hDEADBEEF, 0, 32'h0,        1'b0, "SW 0x10");
      do_txn(0, 1'b0, LB,  10'h013, 32'h0,        0, 32'hFFFFFFDE, 1'b0, "LB 0x13");
      do_txn(0, 1'b0, LBU, 10'h013, 32'h0,        0, 32'h000000DE, 1'b0, "LBU 0x13");
      do_txn(0, 1'b0, LH,  10'h012, 32'h0,        0, 32'hFFFFDEAD, 1'b0, "LH 0x12");
      do_txn(0, 1'b0, LHU, 10'h010, 32'h0,        0, 32'h0000BEEF, 1'b0, "LHU 0x10");
      do_txn(0, 1'b1, SB,  10'h001, 32'hA5A5A55A, 0, 32'h0,        1'b0, "SB 0x01");
      do_txn(0, 1'b0, LW,  10'h000, 32'h0,        0, 32'h00005A11, 1'b0, "LW 0x00 after SB");
      do_txn(0, 1'b0, LW,  10'h004, 32'h0,        0, 32'd9,        1'b0, "LW 0x04 untouched");
      do_txn(0, 1'b0, LW,  10'h008, 32'h0,        0, 32'd25,       1'b0, "LW 0x08 untouched");
      do_txn(0, 1'b1, SH,  10'h012, 32'h1234CAFE, 0, 32'h0,        1'b0, "SH 0x12");
      do_txn(0, 1'b0, LW,  10'h010, 32'h0,        0, 32'hCAFEBEEF, 1'b0, "LW 0x10 after SH");
      do_txn(0, 1'b0, LH,  10'h010, 32'h0,        0, 32'hFFFFBEEF, 1'b0, "LH 0x10");
      do_txn(0, 1'b0, LB,  10'h011, 32'h0,        0, 32'hFFFFFFBE, 1'b0, "LB 0x11");
      do_txn(0, 1'b0, LBU, 10'h010, 32'h0,        0, 32'h000000EF, 1'b0, "LBU 0x10");

      // Illegal funct3 and out-of-range accesses.
      do_txn(0, 1'b0, 3'b111, 10'h000, 32'h0,        0, 32'h0, 1'b1, "load f3=111");
      do_txn(0, 1'b0, 3'b011, 10'h000, 32'h0,        0, 32'h0, 1'b1, "load f3=011");
      do_txn(0, 1'b0, 3'b110, 10'h000, 32'h0,        0, 32'h0, 1'b1, "load f3=110");
      do_txn(0, 1'b1, 3'b100, 10'h000, 32'hFFFFFFFF, 0, 32'h0, 1'b1, "store f3=100");
      do_txn(0, 1'b1, 3'b011, 10'h000, 32'hFFFFFFFF, 0, 32'h0, 1'b1, "store f3=011");
      do_txn(0, 1'b0, LW,     10'h000, 32'h0,        0, 32'h00005A11, 1'b0, "LW 0x00 after bad stores");
      do_txn(0, 1'b0, LW,     10'h100, 32'h0,        0, 32'h0, 1'b1, "LW 0x100 out of range");
      do_txn(0, 1'b1, SW,     10'h104, 32'h77777777, 0, 32'h0, 1'b1, "SW 0x104 out of range");
      do_txn(0, 1'b0, LW,     10'h004, 32'h0,        0, 32'd9, 1'b0, "LW 0x04 after range fault");

      // Misaligned accesses.
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      do_txn(0, 1'b1, SW, 10'h002, 32'h01020304, 0, 32'h0,        1'b1, "SW 0x02 misaligned");
      do_txn(0, 1'b0, LW, 10'h000, 32'h0,        0, 32'h00005A11, 1'b0, "LW 0x00 after misaligned SW");
      do_txn(0, 1'b0, LH, 10'h003, 32'h0,        0, 32'h0,        1'b1, "LH 0x03 misaligned");
      do_txn(0, 1'b0, LW, 10'h011, 32'h0,        0, 32'h0,        1'b1, "LW 0x11 misaligned");
`else
      do_txn(0, 1'b1, SW, 10'h002, 32'h01020304, 0, 32'h0,        1'b0, "SW 0x02 misaligned");
      do_txn(0, 1'b0, LW, 10'h000, 32'h0,        0, 32'h01020304, 1'b0, "LW 0x00 after misaligned SW");
      do_txn(0, 1'b0, LH, 10'h003, 32'h0,        0, 32'h00000102, 1'b0, "LH 0x03 misaligned");
      do_txn(0, 1'b0, LW, 10'h011, 32'h0,        0, 32'hCAFEBEEF, 1'b0, "LW 0x11 misaligned");
`endif

      // Three-wait-state instance, with and without consumer back-pressure.
      do_txn(1, 1'b1, SW, 10'h00C, 32'h0BADF00D, 5, 32'h0,        1'b0, "b SW 0x0C stalled");
      do_txn(1, 1'b0, LW, 10'h00C, 32'h0,        5, 32'h0BADF00D, 1'b0, "b LW 0x0C stalled");
      do_txn(1, 1'b0, LW, 10'h004, 32'h0,        0, 32'd9,        1'b0, "b LW 0x04");
      do_txn(1, 1'b0, LB, 10'h00D, 32'h0,        0, 32'hFFFFFFF0, 1'b0, "b LB 0x0D");

      // Reset while a response is pending on dut a: the response is dropped.
      cmp_en = 1'b0;
      @(negedge clk);
      req_we       = 1'b0;
      req_funct3   = LW;
      req_addr     = 10'h004;
      req_valid[0] = 1'b1;
      rsp_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst-in-RESP pending rsp_valid", 32'(rsp_valid_a), 32'd1);
      check("rst-in-RESP pending rsp_rdata", rsp_rdata_a, 32'd9);
      rst = 1'b1;
      #1;
      chk_reset("rst in RESP");
      @(negedge clk);
      rst          = 1'b0;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk_reset("after rst in RESP");

      // Reset while a store waits on dut b: the store is abandoned.
      req_we       = 1'b1;
      req_funct3   = SW;
      req_addr     = 10'h008;
      req_wdata    = 32'h11223344;
      req_valid[1] = 1'b1;
      rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("rst-in-WAIT accepted req_ready", 32'(req_ready_b), 32'd0);
      rst = 1'b1;
      #1;
      chk_reset("rst in WAIT");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset("after rst in WAIT");
      cmp_en = 1'b1;

      do_txn(1, 1'b0, LW, 10'h008, 32'h0, 0, 32'd25, 1'b0, "b LW 0x08 after abort");
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      do_txn(0, 1'b0, LW, 10'h000, 32'h0, 0, 32'h00005A11, 1'b0, "LW 0x00 survives reset");
`else
      do_txn(0, 1'b0, LW, 10'h000, 32'h0, 0, 32'h01020304, 1'b0, "LW 0x00 survives reset");
`endif

      @(negedge clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
